affine_seq: RTL

AFFINE_SEQ -- requirements
Module: affine_seq

---
 rtl/affine_pkg.sv | 12 +
 rtl/affine_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/affine_pkg.sv
// Shared widths and the sequencer state type for the affine program sequencer.
package affine;
  localparam int A      = 8;
  localparam int W_INST = 28;
  localparam int W_ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/affine_seq.sv
// Program sequencer: fetches instructions from an external ROM and issues them
// over a valid/ready handshake, repeating the program for a latched pass count.
module affine_seq #(
  parameter int A      = affine::A,
  parameter int W_INST = affine::W_INST
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      halt_i,
  input  logic [A-1:0]              prog_len_i,
  input  logic [affine::W_ITER-1:0] iter_i,
  output logic [A-1:0]              rom_addr_o,
  input  logic [W_INST-1:0]         rom_data_i,
  output logic [W_INST-1:0]         inst_o,
  output logic                      inst_valid_o,
  input  logic                      inst_ready_i,
  output logic [affine::W_ITER-1:0] pass_o,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int WI = affine::W_ITER;

  // Handshake: an instruction transfers on any edge where inst_valid_o and
  // inst_ready_i are both high; while ready is low, inst_o/inst_valid_o hold.

  affine::seq_state_t state_q, state_d;
  logic [A-1:0]      pc_q, pc_d;
  logic [A-1:0]      len_q, len_d;
  logic [WI-1:0]     iter_q, iter_d;
  logic [WI-1:0]     pass_q, pass_d;
  logic [W_INST-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  logic accept;
  logic last;
  logic more;

  assign accept = valid_q & inst_ready_i;
  assign last   = (pc_q == len_q);
  // 17-bit compare so pass_q+1 cannot wrap into a false "more passes remain"
  assign more   = (iter_q == '0) || (({1'b0, pass_q} + 17'd1) < {1'b0, iter_q});

  // When the current word is the last one, prefetch rom[0] for the next pass.
  assign rom_addr_o = (state_q == affine::RUN && !last) ? pc_q + A'(1) : '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    iter_d  = iter_q;
    pass_d  = pass_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    case (state_q)
      affine::IDLE: begin
        if (start_i) begin
          state_d = affine::RUN;
          pc_d    = '0;
          pass_d  = '0;
          len_d   = prog_len_i;
          iter_d  = iter_i;
          inst_d  = rom_data_i;
          valid_d = 1'b1;
        end
      end
      affine::RUN: begin
        if (accept) begin
          if (!last) begin
            pc_d   = pc_q + A'(1);
            inst_d = rom_data_i;
          end else begin
            pass_d = pass_q + WI'(1);
            if (more) begin
              pc_d   = '0;
              inst_d = rom_data_i;
            end else begin
              valid_d = 1'b0;
              state_d = affine::DONE;
            end
          end
        end
        // A coincident accept above still counts; halt only stops further issue.
        if (halt_i) begin
          valid_d = 1'b0;
          state_d = affine::IDLE;
        end
      end
      affine::DONE: begin
        state_d = affine::IDLE;
      end
      default: begin
        state_d = affine::IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= affine::IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      iter_q  <= '0;
      pass_q  <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      iter_q  <= iter_d;
      pass_q  <= pass_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign pass_o       = pass_q;
  assign busy_o       = (state_q == affine::RUN);
  assign done_o       = (state_q == affine::DONE);
endmodule
